// File: rtl/ifid_skid_reg.sv
// IF/ID stage register with a 2-entry skid buffer (main + skid) and decode-field slicing.
// Optional IFID_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module ifid_skid_reg #(
    parameter int n = 32,
    parameter int i = n / 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         if_valid,
    output logic         if_ready,
    input  logic [n-1:0] if_instr,
    input  logic [n-1:0] if_pcplus4,
    output logic         id_valid,
    input  logic         id_ready,
    output logic [n-1:0] id_instr,
    output logic [n-1:0] id_pcplus4,
    output logic [5:0]   id_op,
    output logic [4:0]   id_rs,
    output logic [4:0]   id_rt,
    output logic [4:0]   id_rd,
    output logic [4:0]   id_shamt,
    output logic [5:0]   id_funct,
`ifdef IFID_PERF_CNT_EN
    output logic [31:0]  stall_cnt,
    output logic [31:0]  flush_cnt,
`endif
    output logic [i-1:0] id_imm
);

    // State bits double as the entry valids: bit0 = main valid, bit1 = skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t       state, next_state;
    logic         accept, consume;
    logic         load_main, load_skid, move_skid;
    logic [n-1:0] skid_instr, skid_pcplus4;

    assign accept   = if_valid & if_ready;
    assign consume  = id_valid & id_ready;
    assign id_valid = state[0];

    always_comb begin
        next_state = state;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        next_state = ONE;
                        load_main  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !consume) begin
                        next_state = FULL;
                        load_skid  = 1'b1;
                    end else if (!accept && consume) begin
                        next_state = EMPTY;
                    end else if (accept && consume) begin
                        load_main = 1'b1;
                    end
                end
                FULL: begin
                    if (consume) begin
                        next_state = ONE;
                        move_skid  = 1'b1;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            if_ready <= 1'b1;
        end else begin
            state    <= next_state;
            if_ready <= (next_state != FULL);
        end
    end

    // Payloads only move on accept or skid drain; flush leaves stale data behind id_valid=0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_instr     <= '0;
            id_pcplus4   <= '0;
            skid_instr   <= '0;
            skid_pcplus4 <= '0;
        end else begin
            if (load_main) begin
                id_instr   <= if_instr;
                id_pcplus4 <= if_pcplus4;
            end else if (move_skid) begin
                id_instr   <= skid_instr;
                id_pcplus4 <= skid_pcplus4;
            end
            if (load_skid) begin
                skid_instr   <= if_instr;
                skid_pcplus4 <= if_pcplus4;
            end
        end
    end

    assign id_op    = id_instr[31:26];
    assign id_rs    = id_instr[25:21];
    assign id_rt    = id_instr[20:16];
    assign id_rd    = id_instr[15:11];
    assign id_shamt = id_instr[10:6];
    assign id_funct = id_instr[5:0];
    assign id_imm   = id_instr[i-1:0];

`ifdef IFID_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (if_valid && !if_ready) stall_cnt <= sat_inc(stall_cnt);
            if (flush)                 flush_cnt <= sat_inc(flush_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Directed self-checking bench for ifid_skid_reg; define IFID_PERF_CNT_EN to also check counters.
module tb_ifid_skid_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pcplus4;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pcplus4;
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    ifid_skid_reg #(.n(32), .i(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pcplus4(if_pcplus4),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pcplus4(id_pcplus4),
        .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct),
`ifdef IFID_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .id_imm(id_imm)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_instr = 32'h0; if_pcplus4 = 32'h0;
        tick(); tick();
        total++; if (if_ready !== 1'b1) $display("FAIL reset_if_ready got=%b exp=1", if_ready); else pass_cnt++;
        total++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid got=%b exp=0", id_valid); else pass_cnt++;
        total++; if (id_instr !== 32'h0) $display("FAIL reset_id_instr got=%h exp=0", id_instr); else pass_cnt++;
        total++; if (id_pcplus4 !== 32'h0) $display("FAIL reset_id_pcplus4 got=%h exp=0", id_pcplus4); else pass_cnt++;
        total++; if (id_imm !== 16'h0) $display("FAIL reset_id_imm got=%h exp=0", id_imm); else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        id_ready = 1'b1; if_valid = 1'b1;
        if_instr = 32'h2008_8000; if_pcplus4 = 32'h0040_0004;
        tick();
        if_valid = 1'b0;
        total++; if (id_valid !== 1'b1) $display("FAIL basic_id_valid got=%b exp=1", id_valid); else pass_cnt++;
        total++; if (id_op !== 6'h08) $display("FAIL basic_op got=%h exp=08", id_op); else pass_cnt++;
        total++; if (id_rs !== 5'd0) $display("FAIL basic_rs got=%0d exp=0", id_rs); else pass_cnt++;
        total++; if (id_rt !== 5'd8) $display("FAIL basic_rt got=%0d exp=8", id_rt); else pass_cnt++;
        total++; if (id_rd !== 5'd16) $display("FAIL basic_rd got=%0d exp=16", id_rd); else pass_cnt++;
        total++; if (id_shamt !== 5'd0) $display("FAIL basic_shamt got=%0d exp=0", id_shamt); else pass_cnt++;
        total++; if (id_funct !== 6'd0) $display("FAIL basic_funct got=%0d exp=0", id_funct); else pass_cnt++;
        total++; if (id_imm !== 16'h8000) $display("FAIL basic_imm got=%h exp=8000", id_imm); else pass_cnt++;
        total++; if (id_pcplus4 !== 32'h0040_0004) $display("FAIL basic_pcplus4 got=%h exp=00400004", id_pcplus4); else pass_cnt++;
        tick();
        total++; if (id_valid !== 1'b0) $display("FAIL basic_drain got=%b exp=0", id_valid); else pass_cnt++;
    endtask

    task automatic test_stream();
        id_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if_valid = 1'b1; if_instr = k; if_pcplus4 = k * 4;
            tick();
            total++; if (if_ready !== 1'b1) $display("FAIL stream_if_ready k=%0d got=%b exp=1", k, if_ready); else pass_cnt++;
            total++; if (id_valid !== 1'b1 || id_instr !== k)
                $display("FAIL stream_data k=%0d got=%b/%h exp=1/%h", k, id_valid, id_instr, k);
            else pass_cnt++;
            total++; if (id_pcplus4 !== k * 4) $display("FAIL stream_pc k=%0d got=%h exp=%h", k, id_pcplus4, k * 4); else pass_cnt++;
        end
        if_valid = 1'b0;
        tick();
        total++; if (id_valid !== 1'b0) $display("FAIL stream_drain got=%b exp=0", id_valid); else pass_cnt++;
    endtask

    task automatic test_skid();
        id_ready = 1'b0; if_valid = 1'b1; if_instr = 32'hA; if_pcplus4 = 32'h100;
        tick();
        total++; if (id_instr !== 32'hA || if_ready !== 1'b1) $display("FAIL skid_one got=%h/%b exp=a/1", id_instr, if_ready); else pass_cnt++;
        if_instr = 32'hB; if_pcplus4 = 32'h104;
        tick();
        total++; if (id_instr !== 32'hA || if_ready !== 1'b0 || id_valid !== 1'b1)
            $display("FAIL skid_full got=%h/%b/%b exp=a/0/1", id_instr, if_ready, id_valid);
        else pass_cnt++;
        if_instr = 32'hC; if_pcplus4 = 32'h108;
        for (int s = 0; s < 2; s++) begin
            tick();
            total++; if (id_instr !== 32'hA || id_pcplus4 !== 32'h100 || if_ready !== 1'b0)
                $display("FAIL skid_hold s=%0d got=%h/%h/%b exp=a/100/0", s, id_instr, id_pcplus4, if_ready);
            else pass_cnt++;
        end
        id_ready = 1'b1;
        tick();
        total++; if (id_instr !== 32'hB || id_pcplus4 !== 32'h104 || if_ready !== 1'b1)
            $display("FAIL skid_drain_b got=%h/%h/%b exp=b/104/1", id_instr, id_pcplus4, if_ready);
        else pass_cnt++;
        tick();
        if_valid = 1'b0;
        total++; if (id_instr !== 32'hC || id_valid !== 1'b1) $display("FAIL skid_drain_c got=%h/%b exp=c/1", id_instr, id_valid); else pass_cnt++;
        tick();
        total++; if (id_valid !== 1'b0) $display("FAIL skid_empty got=%b exp=0", id_valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        id_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h11;
        tick();
        if_instr = 32'h12;
        tick();
        total++; if (if_ready !== 1'b0) $display("FAIL flush_prefull got=%b exp=0", if_ready); else pass_cnt++;
        flush = 1'b1; if_instr = 32'hD;
        tick();
        flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
        total++; if (id_valid !== 1'b0 || if_ready !== 1'b1)
            $display("FAIL flush_empty got=%b/%b exp=0/1", id_valid, if_ready);
        else pass_cnt++;
        for (int s = 0; s < 3; s++) begin
            tick();
            total++; if (id_valid !== 1'b0) $display("FAIL flush_no_d s=%0d got=%b/%h exp=0", s, id_valid, id_instr); else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        id_ready = 1'b1; if_valid = 1'b1; if_instr = 32'h55; if_pcplus4 = 32'h58;
        tick();
        total++; if (id_valid !== 1'b1 || id_instr !== 32'h55) $display("FAIL ares_pre got=%b/%h exp=1/55", id_valid, id_instr); else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total++; if (id_valid !== 1'b0) $display("FAIL ares_id_valid got=%b exp=0", id_valid); else pass_cnt++;
        total++; if (if_ready !== 1'b1) $display("FAIL ares_if_ready got=%b exp=1", if_ready); else pass_cnt++;
        total++; if (id_instr !== 32'h0 || id_pcplus4 !== 32'h0)
            $display("FAIL ares_payload got=%h/%h exp=0/0", id_instr, id_pcplus4);
        else pass_cnt++;
        if_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

`ifdef IFID_PERF_CNT_EN
    task automatic test_perf();
        total++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        else pass_cnt++;
        id_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h1;
        tick();
        if_instr = 32'h2;
        tick();
        tick(); tick(); tick();
        if_valid = 1'b0; flush = 1'b1;
        tick(); tick();
        flush = 1'b0;
        total++; if (stall_cnt !== 32'd3) $display("FAIL perf_stall got=%0d exp=3", stall_cnt); else pass_cnt++;
        total++; if (flush_cnt !== 32'd2) $display("FAIL perf_flush got=%0d exp=2", flush_cnt); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_skid();
        test_flush();
        test_async_reset();
`ifdef IFID_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
